dn_stream_loader: RTL and testbench

- Transmitter side of the ROM-upload port: drives dn_addr/dn_wr/dn_data/dn_index into the system module's pgrom/chrom/palrom/spriterom write ports.
- Accepts a framed byte stream (valid/ready) from the HPS/UART bridge, unpacks header and payload into paced single-cycle write strobes, and verifies an XOR checksum.
- Asserts downloading so the top level can hold the CPU in reset during an upload.

---
 rtl/dn_stream_loader.sv | 189 ++++++++++++++++++
 tb/tb_dn_stream_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dn_stream_loader.sv
// ROM-upload transmitter: turns a framed byte stream into paced single-cycle ROM write strobes
// and verifies the frame's XOR checksum.
module dn_stream_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned WR_GAP    = 3,
  parameter logic [16:0] MAX_LEN   = 17'h1_0000
) (
  input  logic        clk_24,
  input  logic        reset_n,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [16:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic [7:0]  dn_index,
  output logic        dn_wr,
  output logic        downloading,
  output logic        done,
  output logic        err_len,
  output logic        err_csum
);

  typedef enum logic [2:0] {
    StIdle, StIndex, StLen0, StLen1, StLen2, StData, StCsum, StDone
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  gap_q, gap_d;
  logic [7:0]  csum_q, csum_d;
  logic [16:0] len_q, len_d;
  logic [16:0] offset_q, offset_d;
  logic [16:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  index_q, index_d;
  logic        wr_q, wr_d;
  logic        dl_q, dl_d;
  logic        done_q, done_d;
  logic        err_len_q, err_len_d;
  logic        err_csum_q, err_csum_d;

  logic        accept;
  logic [16:0] len_full;
  logic        len_bad;

  // Payload and checksum bytes wait for the post-write gap to drain.
  always_comb begin
    s_ready = 1'b1;
    unique case (state_q)
      StData, StCsum: s_ready = (gap_q == 4'd0);
      StDone:         s_ready = 1'b0;
      default:        s_ready = 1'b1;
    endcase
  end

  assign accept   = s_valid && s_ready;
  assign len_full = {s_data[0], len_q[15:0]};
  assign len_bad  = (s_data[7:1] != 7'd0) || (len_full > MAX_LEN);

  always_comb begin
    state_d    = state_q;
    gap_d      = (gap_q != 4'd0) ? gap_q - 4'd1 : 4'd0;
    csum_d     = csum_q;
    len_d      = len_q;
    offset_d   = offset_q;
    addr_d     = addr_q;
    data_d     = data_q;
    index_d    = index_q;
    wr_d       = 1'b0;
    dl_d       = dl_q;
    done_d     = 1'b0;
    err_len_d  = err_len_q;
    err_csum_d = err_csum_q;

    unique case (state_q)
      StIdle: begin
        if (accept && s_data == SYNC_BYTE) begin
          state_d    = StIndex;
          err_len_d  = 1'b0;
          err_csum_d = 1'b0;
          csum_d     = 8'd0;
        end
      end
      StIndex: begin
        if (accept) begin
          index_d = s_data;
          csum_d  = csum_q ^ s_data;
          dl_d    = 1'b1;
          state_d = StLen0;
        end
      end
      StLen0: begin
        if (accept) begin
          len_d[7:0] = s_data;
          csum_d     = csum_q ^ s_data;
          state_d    = StLen1;
        end
      end
      StLen1: begin
        if (accept) begin
          len_d[15:8] = s_data;
          csum_d      = csum_q ^ s_data;
          state_d     = StLen2;
        end
      end
      StLen2: begin
        if (accept) begin
          len_d    = len_full;
          csum_d   = csum_q ^ s_data;
          offset_d = 17'd0;
          if (len_bad) begin
            err_len_d = 1'b1;
            done_d    = 1'b1;
            dl_d      = 1'b0;
            state_d   = StIdle;
          end else if (len_full == 17'd0) begin
            state_d = StCsum;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          wr_d     = 1'b1;
          data_d   = s_data;
          addr_d   = offset_q;
          offset_d = offset_q + 17'd1;
          csum_d   = csum_q ^ s_data;
          gap_d    = 4'(WR_GAP);
          if (offset_q == len_q - 17'd1) state_d = StCsum;
        end
      end
      StCsum: begin
        if (accept) begin
          err_csum_d = (s_data != csum_q);
          done_d     = 1'b1;
          dl_d       = 1'b0;
          state_d    = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_24 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      gap_q      <= 4'd0;
      csum_q     <= 8'd0;
      len_q      <= 17'd0;
      offset_q   <= 17'd0;
      addr_q     <= 17'd0;
      data_q     <= 8'd0;
      index_q    <= 8'd0;
      wr_q       <= 1'b0;
      dl_q       <= 1'b0;
      done_q     <= 1'b0;
      err_len_q  <= 1'b0;
      err_csum_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      csum_q     <= csum_d;
      len_q      <= len_d;
      offset_q   <= offset_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      index_q    <= index_d;
      wr_q       <= wr_d;
      dl_q       <= dl_d;
      done_q     <= done_d;
      err_len_q  <= err_len_d;
      err_csum_q <= err_csum_d;
    end
  end

  assign dn_addr     = addr_q;
  assign dn_data     = data_q;
  assign dn_index    = index_q;
  assign dn_wr       = wr_q;
  assign downloading = dl_q;
  assign done        = done_q;
  assign err_len     = err_len_q;
  assign err_csum    = err_csum_q;

endmodule

// File: tb/tb_dn_stream_loader.sv
// Directed + randomized bench for dn_stream_loader against a frame-level reference model.
module tb_dn_stream_loader;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int GAP = 3;

  logic        clk_24 = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  s_data = 8'd0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [16:0] dn_addr;
  logic [7:0]  dn_data;
  logic [7:0]  dn_index;
  logic        dn_wr;
  logic        downloading;
  logic        done;
  logic        err_len;
  logic        err_csum;

  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [16:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  logic [7:0]  wr_idx_q[$];
  int          wr_cyc_q[$];

  dn_stream_loader #(.SYNC_BYTE(SYNC), .WR_GAP(GAP), .MAX_LEN(17'h1_0000)) dut (
    .clk_24(clk_24), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .dn_addr(dn_addr), .dn_data(dn_data), .dn_index(dn_index), .dn_wr(dn_wr),
    .downloading(downloading), .done(done), .err_len(err_len), .err_csum(err_csum)
  );

  always #5 clk_24 = ~clk_24;
  always @(posedge clk_24) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write/done monitor, sampled mid-cycle.
  always @(negedge clk_24) begin
    if (done === 1'b1) done_cnt++;
    if (dn_wr === 1'b1) begin
      wr_addr_q.push_back(dn_addr);
      wr_data_q.push_back(dn_data);
      wr_idx_q.push_back(dn_index);
      wr_cyc_q.push_back(cyc);
      chk("dl_during_wr", 32'(downloading), 32'd1);
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int t = 0;
    bit ok = 0;
    while (!ok && t < 200) begin
      @(negedge clk_24);
      t++;
      if (rnd && $urandom_range(0, 2) == 0) begin
        s_valid = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_data  = b;
        #1;
        if (s_ready) begin
          @(posedge clk_24);
          ok = 1;
        end
      end
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_bus();
    @(negedge clk_24);
    s_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (done_cnt == 0 && t < 40) begin
      @(negedge clk_24);
      t++;
    end
    repeat (2) @(negedge clk_24);
    chk("done_pulses", 32'(done_cnt), 32'd1);
  endtask

  task automatic clear_mon();
    wr_addr_q.delete(); wr_data_q.delete(); wr_idx_q.delete(); wr_cyc_q.delete();
    done_cnt = 0;
  endtask

  // Reference: build frame from index/payload; expected writes are payload[i] at addr i.
  task automatic run_frame(input logic [7:0] idx, input logic [7:0] pay[$],
                           input logic [7:0] cx, input bit rnd);
    logic [16:0] len;
    logic [7:0]  cs;
    int n;
    n   = pay.size();
    len = 17'(n);
    cs  = idx ^ len[7:0] ^ len[15:8] ^ {7'd0, len[16]};
    foreach (pay[i]) cs ^= pay[i];
    clear_mon();
    send_byte(SYNC, rnd);
    #1;
    chk("sync_clr_csum", 32'(err_csum), 32'd0);
    chk("sync_clr_len", 32'(err_len), 32'd0);
    send_byte(idx, rnd);
    #1;
    chk("dl_after_index", 32'(downloading), 32'd1);
    send_byte(len[7:0], rnd);
    send_byte(len[15:8], rnd);
    send_byte({7'd0, len[16]}, rnd);
    foreach (pay[i]) send_byte(pay[i], rnd);
    send_byte(cs ^ cx, rnd);
    idle_bus();
    wait_done();
    chk("wr_count", 32'(wr_addr_q.size()), 32'(n));
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      chk("wr_addr", 32'(wr_addr_q[i]), 32'(i));
      chk("wr_data", 32'(wr_data_q[i]), 32'(pay[i]));
      chk("wr_index", 32'(wr_idx_q[i]), 32'(idx));
      if (i > 0) begin
        if (rnd) chk("wr_min_gap", 32'(wr_cyc_q[i] - wr_cyc_q[i-1] >= GAP + 1), 32'd1);
        else     chk("wr_spacing", 32'(wr_cyc_q[i] - wr_cyc_q[i-1]), 32'(GAP + 1));
      end
    end
    chk("err_csum", 32'(err_csum), 32'(cx != 8'd0));
    chk("err_len_clean", 32'(err_len), 32'd0);
    chk("dl_after_done", 32'(downloading), 32'd0);
  endtask

  initial begin
    logic [7:0] pay[$];
    #3;
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_dn_wr", 32'(dn_wr), 32'd0);
    chk("rst_dl", 32'(downloading), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_errs", 32'({err_len, err_csum}), 32'd0);
    chk("rst_addr", 32'(dn_addr), 32'd0);
    @(negedge clk_24);
    reset_n = 1'b1;

    // Nominal frame, checksum 0x40
    pay = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(8'h00, pay, 8'h00, 1'b0);
    // Bad checksum: writes still land, flag sticky
    run_frame(8'h00, pay, 8'h01, 1'b0);
    repeat (5) @(negedge clk_24);
    chk("err_csum_sticky", 32'(err_csum), 32'd1);
    // Zero length
    pay.delete();
    run_frame(8'h01, pay, 8'h00, 1'b0);

    // Oversized length 0x10001
    clear_mon();
    send_byte(SYNC, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    idle_bus();
    wait_done();
    chk("len_err", 32'(err_len), 32'd1);
    chk("len_no_wr", 32'(wr_addr_q.size()), 32'd0);
    chk("len_dl", 32'(downloading), 32'd0);
    chk("len_idle_ready", 32'(s_ready), 32'd1);
    pay = '{8'hA5, 8'h5A, 8'hC3};
    run_frame(8'h02, pay, 8'h00, 1'b0);

    // Junk then a 2-byte frame, random valid
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h12, 1'b1);
    pay = '{8'h77, 8'h88};
    run_frame(8'h03, pay, 8'h00, 1'b1);

    // Reset during payload byte 2 of 4
    clear_mon();
    send_byte(SYNC, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    #2;
    s_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_dl", 32'(downloading), 32'd0);
    chk("rst_mid_wr", 32'(dn_wr), 32'd0);
    chk("rst_mid_ready", 32'(s_ready), 32'd1);
    @(negedge clk_24);
    reset_n = 1'b1;
    pay = '{8'h01, 8'h02, 8'h03};
    run_frame(8'h01, pay, 8'h00, 1'b0);

    // Random frames
    for (int f = 0; f < 4; f++) begin
      int n;
      n = $urandom_range(1, 6);
      pay.delete();
      for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
      run_frame(8'($urandom_range(0, 3)), pay, (f == 2) ? 8'h5A : 8'h00, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
